// File: rtl/arb_pkg.sv
// Shared types and helpers for the registered priority arbiter.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Round-robin search origin: one below the last winner, wrapping to n-1.
    function automatic int unsigned rr_start(input int unsigned last, input int unsigned n);
        return (last == 0) ? n - 1 : last - 1;
    endfunction

endpackage

// File: rtl/priority_pick.sv
// Combinational priority pick: first unmasked request found searching downward
// from a start index, wrapping from 0 back to N-1.
module priority_pick #(
    parameter  int unsigned N    = 8,
    localparam int unsigned IDXW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    mask,
    input  logic [IDXW-1:0] start,
    output logic [N-1:0]    onehot,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    logic [IDXW-1:0] pos;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = IDXW'((32'(start) + N - k) % N);
            if (!any && req[pos] && !mask[pos]) begin
                any         = 1'b1;
                idx         = pos;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter: fixed or round-robin priority, grant held until
// release or until the hold budget expires while others wait.
module priority_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned N        = 8,
    parameter  int unsigned MAX_HOLD = 0,
    localparam int unsigned IDXW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            rr_en,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid
);

    localparam int unsigned HCW = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1);

    arb_state_t      state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [IDXW-1:0] last_idx_q, last_idx_d;
    logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;

    logic            owner_req_c;
    logic            others_c;
    logic            preempt_c;
    logic            new_grant_c;
    logic [IDXW-1:0] start_c;
    logic [N-1:0]    mask_c;
    logic [N-1:0]    pick_onehot;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;

    // The current owner is excluded whenever we re-arbitrate out of a grant.
    always_comb begin
        owner_req_c = req[gnt_idx_q];
        others_c    = |(req & ~gnt_q);
        start_c     = rr_en ? IDXW'(rr_start(32'(last_idx_q), N)) : IDXW'(N - 1);
        mask_c      = (state_q == ARB_GRANT) ? gnt_q : '0;
        preempt_c   = (MAX_HOLD > 0) && (state_q == ARB_GRANT) && owner_req_c && others_c
                      && (hold_cnt_q == HCW'(MAX_HOLD - 1));
        new_grant_c = pick_any && ((state_q == ARB_IDLE) || !owner_req_c || preempt_c);
    end

    priority_pick #(.N(N)) u_pick (
        .req    (req),
        .mask   (mask_c),
        .start  (start_c),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            last_idx_q  <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            last_idx_q  <= last_idx_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (pick_any) state_d = ARB_GRANT;
            ARB_GRANT: if (!owner_req_c && !pick_any) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Next values of the registered grant outputs and bookkeeping.
    always_comb begin
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        hold_cnt_d = hold_cnt_q;
        if (new_grant_c) begin
            gnt_d      = pick_onehot;
            gnt_idx_d  = pick_idx;
            last_idx_d = pick_idx;
            hold_cnt_d = '0;
        end else if (state_q == ARB_GRANT && !owner_req_c) begin
            gnt_d      = '0;
            gnt_idx_d  = '0;
            hold_cnt_d = '0;
        end else if (state_q == ARB_GRANT && others_c && hold_cnt_q != HCW'(MAX_HOLD)) begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
        end
        gnt_valid_d = |gnt_d;
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Randomized self-checking bench for priority_arbiter (N=8) with two instances:
// MAX_HOLD=4 and MAX_HOLD=0, both compared against an ownership-level model.
module tb_priority_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_en;

    logic [7:0] gnt4, gnt0;
    logic [2:0] idx4, idx0;
    logic       vld4, vld0;

    int checks   = 0;
    int failures = 0;

    // Model state per instance: index 0 -> MAX_HOLD=4, index 1 -> MAX_HOLD=0.
    int own [2];
    int lst [2];
    int cnt [2];
    int mh  [2];

    priority_arbiter #(.N(8), .MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4)
    );

    priority_arbiter #(.N(8), .MAX_HOLD(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .rr_en(rr_en),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            own[m] = -1;
            lst[m] = 0;
            cnt[m] = 0;
        end
    endfunction

    // Choose a new owner per the ordering rules, skipping index msk.
    function automatic void model_pick(input int m, input logic [7:0] r, input logic rr, input int msk);
        int win;
        win = -1;
        for (int k = 0; k < 8; k++) begin
            int i;
            i = rr ? ((((lst[m] - 1 - k) % 8) + 8) % 8) : (7 - k);
            if (win < 0 && r[i[2:0]] && i != msk) win = i;
        end
        own[m] = win;
        if (win >= 0) lst[m] = win;
        cnt[m] = 0;
    endfunction

    function automatic void model_step(input int m, input logic [7:0] r, input logic rr);
        logic [7:0] oth;
        int         o;
        if (own[m] < 0) begin
            model_pick(m, r, rr, -1);
            return;
        end
        o = own[m];
        oth = r;
        oth[o[2:0]] = 1'b0;
        if (!r[o[2:0]]) begin
            model_pick(m, r, rr, o);
        end else if (oth != 8'h00) begin
            if (mh[m] > 0 && cnt[m] == mh[m] - 1) model_pick(m, r, rr, o);
            else if (cnt[m] < mh[m]) cnt[m]++;
        end
    endfunction

    function automatic logic [7:0] exp_gnt(input int m);
        logic [7:0] g;
        g = 8'h00;
        if (own[m] >= 0) g[own[m][2:0]] = 1'b1;
        return g;
    endfunction

    function automatic logic [2:0] exp_idx(input int m);
        return (own[m] >= 0) ? 3'(own[m]) : 3'd0;
    endfunction

    task automatic compare_all();
        chk("h4_gnt", 32'(gnt4), 32'(exp_gnt(0)));
        chk("h4_idx", 32'(idx4), 32'(exp_idx(0)));
        chk("h4_vld", 32'(vld4), 32'(own[0] >= 0));
        chk("h0_gnt", 32'(gnt0), 32'(exp_gnt(1)));
        chk("h0_idx", 32'(idx0), 32'(exp_idx(1)));
        chk("h0_vld", 32'(vld0), 32'(own[1] >= 0));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(0, req, rr_en);
            model_step(1, req, rr_en);
        end
        #1;
        compare_all();
    endtask

    // Reset pulse placed between edges so its asynchronous effect is observable.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #3 rst_n = 1'b1;
    endtask

    initial begin
        mh[0] = 4;
        mh[1] = 0;
        model_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        rr_en = 1'b0;

        // Outputs stay clear while reset is held, first grant follows release.
        repeat (3) begin
            tick();
            chk("rst_gnt", 32'(gnt4), 32'h0);
            chk("rst_vld", 32'(vld4), 32'h0);
        end
        #3 rst_n = 1'b1;
        tick();
        chk("first_gnt", 32'(gnt4), 32'h80);
        chk("first_idx", 32'(idx4), 32'd7);
        chk("first_vld", 32'(vld4), 32'd1);

        // Fixed priority, unlimited hold keeps idx 5; release hands over with no bubble.
        async_reset();
        req = 8'h24;
        repeat (20) begin
            tick();
            chk("fixed_hold", 32'(gnt0), 32'h20);
        end
        req = 8'h04;
        tick();
        chk("fixed_handover", 32'(gnt0), 32'h04);

        // Round-robin between 7 and 0, four cycles each under MAX_HOLD=4.
        rr_en = 1'b1;
        async_reset();
        req = 8'h81;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("rr_alt", 32'(idx4), ((c / 4) % 2 == 0) ? 32'd7 : 32'd0);
        end

        // Release to empty.
        async_reset();
        req = 8'h08;
        tick();
        chk("solo_gnt", 32'(gnt4), 32'h08);
        req = 8'h00;
        tick();
        chk("empty_gnt", 32'(gnt4), 32'h00);
        chk("empty_vld", 32'(vld4), 32'd0);

        // Mode switch mid-grant leaves owner alone; next arbitration uses round-robin.
        rr_en = 1'b0;
        async_reset();
        req = 8'h24;
        tick();
        rr_en = 1'b1;
        repeat (3) begin
            tick();
            chk("mode_owner", 32'(idx0), 32'd5);
        end
        req = 8'hA4;
        tick();
        chk("late_req", 32'(idx0), 32'd5);
        req = 8'h84;
        tick();
        chk("mode_next", 32'(idx0), 32'd2);

        // Mid-grant reset clears outputs and restarts the round-robin origin.
        rr_en = 1'b1;
        async_reset();
        req = 8'h20;
        tick();
        chk("pre_rst_idx", 32'(idx4), 32'd5);
        async_reset();
        chk("mid_rst_gnt", 32'(gnt4), 32'h0);
        req = 8'h21;
        tick();
        chk("rr_restart", 32'(idx4), 32'd5);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) req = 8'($urandom) & 8'($urandom);
            if ($urandom_range(15) == 0) rr_en = ~rr_en;
            tick();
            if ($urandom_range(99) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
